// File: rtl/mshr_file_pkg.sv
// Shared definitions for the MSHR file: per-entry state encoding and default line geometry.
package mshr_file_pkg;

    typedef enum logic [1:0] {
        MSHR_FREE = 2'd0,
        MSHR_PEND = 2'd1,
        MSHR_WAKE = 2'd2
    } mshrState_t;

    localparam int LINE_OFF_DEF = 4;

endpackage

// File: rtl/mshr_file_entry.sv
// One MSHR slot: a lifecycle state register plus the line tag of the outstanding miss.
//  state     | meaning
//  MSHR_FREE | slot unused, allocatable
//  MSHR_PEND | line miss outstanding on the bus, tag valid, hits lookups
//  MSHR_WAKE | fill returned this cycle, requesters woken; frees on next edge
module mshr_entry
    import mshr_file_pkg::*;
#(
    parameter int TAG_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             allocEn,
    input  logic             fillMatch,
    input  logic [TAG_W-1:0] allocTag,
    input  logic [TAG_W-1:0] lookupTag,
    output mshrState_t       entState,
    output logic [TAG_W-1:0] entTag,
    output logic             hit
);

    mshrState_t nextState;

    always_ff @(posedge clk) begin
        if (rst) begin
            entState <= MSHR_FREE;
            entTag   <= '0;
        end else begin
            entState <= nextState;
            if (allocEn) entTag <= allocTag;
        end
    end

    always_comb begin
        nextState = entState;
        case (entState)
            MSHR_FREE: if (allocEn) nextState = MSHR_PEND;
            MSHR_PEND: if (fillMatch) nextState = MSHR_WAKE;
            MSHR_WAKE: nextState = MSHR_FREE;
            default:   nextState = MSHR_FREE;
        endcase
    end

    // WAKE entries are deliberately excluded so a completing line is not re-merged.
    assign hit = (entState == MSHR_PEND) && (entTag == lookupTag);

endmodule

// File: rtl/mshr_file.sv
// Miss Status Holding Register file for one cache bank: tracks outstanding line misses,
// merges secondary misses and wakes requesters when the line fill returns.
module mshr_file
    import mshr_file_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int ID_W        = 2,
    parameter int PADDR_W     = 15,
    parameter int LINE_OFF    = LINE_OFF_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PADDR_W-1:0] lookup_pAddress,
    input  logic               alloc_valid,
    input  logic [PADDR_W-1:0] alloc_pAddress,
    input  logic               fill_valid,
    input  logic [PADDR_W-1:0] fill_pAddress,
    output logic               MSHR_HIT,
    output logic               MSHR_FULL,
    output logic [ID_W-1:0]    alloc_id,
    output logic               wake,
    output logic [ID_W-1:0]    wake_id,
    output logic [PADDR_W-1:0] wake_pAddress,
    output logic               fill_orphan,
    output logic [ID_W:0]      occupancy
);

    localparam int TAG_W = PADDR_W - LINE_OFF;

    logic [TAG_W-1:0] lookupTag, allocTag, fillTag;
    assign lookupTag = lookup_pAddress[PADDR_W-1:LINE_OFF];
    assign allocTag  = alloc_pAddress[PADDR_W-1:LINE_OFF];
    assign fillTag   = fill_pAddress[PADDR_W-1:LINE_OFF];

    // Offset bits play no part in line matching.
    logic unusedOffsetBits;
    assign unusedOffsetBits = ^{lookup_pAddress[LINE_OFF-1:0], alloc_pAddress[LINE_OFF-1:0],
                                fill_pAddress[LINE_OFF-1:0]};

    mshrState_t       entState [NUM_ENTRIES];
    logic [TAG_W-1:0] entTag   [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] isFree, isWake, hitVec, allocMatch, fillMatch, allocEn;

    logic            allocAccept, anyFillMatch, foundFree;
    logic [ID_W-1:0] freeIdx, fillIdx;
    logic [TAG_W-1:0] fillLineTag;
    logic [ID_W:0]   wakeCount, occNext;

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : gEntry
        mshr_entry #(.TAG_W(TAG_W)) uEntry (
            .clk       (clk),
            .rst       (rst),
            .allocEn   (allocEn[i]),
            .fillMatch (fillMatch[i]),
            .allocTag  (allocTag),
            .lookupTag (lookupTag),
            .entState  (entState[i]),
            .entTag    (entTag[i]),
            .hit       (hitVec[i])
        );
        assign isFree[i]     = (entState[i] == MSHR_FREE);
        assign isWake[i]     = (entState[i] == MSHR_WAKE);
        assign allocMatch[i] = (entState[i] == MSHR_PEND) && (entTag[i] == allocTag);
        assign fillMatch[i]  = fill_valid && (entState[i] == MSHR_PEND) && (entTag[i] == fillTag);
        assign allocEn[i]    = allocAccept && (freeIdx == ID_W'(i));
    end

    assign MSHR_HIT     = |hitVec;
    assign MSHR_FULL    = ~|isFree;
    assign alloc_id     = freeIdx;
    assign anyFillMatch = |fillMatch;
    // FULL is judged on current state, so a fill freeing a slot later cannot rescue this alloc.
    assign allocAccept  = alloc_valid && !MSHR_FULL && !(|allocMatch);

    always_comb begin
        freeIdx     = '0;
        foundFree   = 1'b0;
        fillIdx     = '0;
        fillLineTag = '0;
        wakeCount   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (isFree[i] && !foundFree) begin
                freeIdx   = ID_W'(i);
                foundFree = 1'b1;
            end
            if (fillMatch[i]) begin
                fillIdx     = ID_W'(i);
                fillLineTag = entTag[i];
            end
            wakeCount = wakeCount + (ID_W+1)'(isWake[i]);
        end
        occNext = occupancy + (ID_W+1)'(allocAccept) - wakeCount;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wake          <= 1'b0;
            wake_id       <= '0;
            wake_pAddress <= '0;
            fill_orphan   <= 1'b0;
            occupancy     <= '0;
        end else begin
            wake        <= anyFillMatch;
            fill_orphan <= fill_valid && !anyFillMatch;
            occupancy   <= occNext;
            if (anyFillMatch) begin
                wake_id       <= fillIdx;
                wake_pAddress <= {fillLineTag, {LINE_OFF{1'b0}}};
            end
        end
    end

endmodule

// File: tb/tb_mshr_file.sv
// Self-checking bench for mshr_file: directed allocs/fills with a wake scoreboard.
module tb_mshr_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] lookup_pAddress, alloc_pAddress, fill_pAddress;
    logic        alloc_valid, fill_valid;
    logic        MSHR_HIT, MSHR_FULL, wake, fill_orphan;
    logic [1:0]  alloc_id, wake_id;
    logic [14:0] wake_pAddress;
    logic [2:0]  occupancy;

    typedef struct {
        logic [1:0]  id;
        logic [14:0] addr;
    } wakeExp_t;

    wakeExp_t sbQ[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mshr_file dut (
        .clk             (clk),
        .rst             (rst),
        .lookup_pAddress (lookup_pAddress),
        .alloc_valid     (alloc_valid),
        .alloc_pAddress  (alloc_pAddress),
        .fill_valid      (fill_valid),
        .fill_pAddress   (fill_pAddress),
        .MSHR_HIT        (MSHR_HIT),
        .MSHR_FULL       (MSHR_FULL),
        .alloc_id        (alloc_id),
        .wake            (wake),
        .wake_id         (wake_id),
        .wake_pAddress   (wake_pAddress),
        .fill_orphan     (fill_orphan),
        .occupancy       (occupancy)
    );

    task automatic checkVal(input string tagName, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tagName, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there after the rising edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (wake) begin
            if (sbQ.size() == 0) begin
                checkVal("wakeUnexpected", 32'd1, 32'd0);
            end else begin
                wakeExp_t e;
                e = sbQ.pop_front();
                checkVal("wakeId", 32'(wake_id), 32'(e.id));
                checkVal("wakeAddr", 32'(wake_pAddress), 32'(e.addr));
            end
        end
    end

    initial begin
        rst = 1'b1;
        alloc_valid = 1'b0; alloc_pAddress = '0;
        fill_valid = 1'b0;  fill_pAddress = '0;
        lookup_pAddress = 15'h040F;
        step();
        checkVal("rstOcc", 32'(occupancy), 32'd0);
        checkVal("rstFull", 32'(MSHR_FULL), 32'd0);
        checkVal("rstHit", 32'(MSHR_HIT), 32'd0);
        checkVal("rstWake", 32'(wake), 32'd0);
        checkVal("rstOrphan", 32'(fill_orphan), 32'd0);
        checkVal("rstAllocId", 32'(alloc_id), 32'd0);
        rst = 1'b0;

        alloc_valid = 1'b1; alloc_pAddress = 15'h0400;
        step();
        alloc_valid = 1'b0;
        checkVal("t1Hit", 32'(MSHR_HIT), 32'd1);
        checkVal("t1Occ", 32'(occupancy), 32'd1);
        checkVal("t1AllocId", 32'(alloc_id), 32'd1);

        alloc_valid = 1'b1; alloc_pAddress = 15'h0400;
        step();
        alloc_valid = 1'b0;
        checkVal("t2Occ", 32'(occupancy), 32'd1);
        checkVal("t2AllocId", 32'(alloc_id), 32'd1);

        alloc_valid = 1'b1; alloc_pAddress = 15'h0400;
        fill_valid = 1'b1;  fill_pAddress = 15'h0400;
        sbQ.push_back('{id: 2'd0, addr: 15'h0400});
        step();
        alloc_valid = 1'b0; fill_valid = 1'b0;
        checkVal("t5OccWake", 32'(occupancy), 32'd1);
        checkVal("t5HitWake", 32'(MSHR_HIT), 32'd0);
        step();
        checkVal("t5OccFree", 32'(occupancy), 32'd0);
        checkVal("t5AllocId", 32'(alloc_id), 32'd0);

        for (int k = 0; k < 4; k++) begin
            alloc_valid = 1'b1; alloc_pAddress = 15'(k * 16);
            step();
        end
        alloc_valid = 1'b0;
        checkVal("t3Full", 32'(MSHR_FULL), 32'd1);
        checkVal("t3Occ", 32'(occupancy), 32'd4);

        alloc_valid = 1'b1; alloc_pAddress = 15'h0040;
        lookup_pAddress = 15'h0040;
        step();
        alloc_valid = 1'b0;
        checkVal("t3OccRej", 32'(occupancy), 32'd4);
        checkVal("t3HitRej", 32'(MSHR_HIT), 32'd0);

        fill_valid = 1'b1; fill_pAddress = 15'h0018;
        sbQ.push_back('{id: 2'd1, addr: 15'h0010});
        step();
        fill_valid = 1'b0;
        checkVal("t4FullWake", 32'(MSHR_FULL), 32'd1);
        checkVal("t4OccWake", 32'(occupancy), 32'd4);
        step();
        checkVal("t4FullFree", 32'(MSHR_FULL), 32'd0);
        checkVal("t4AllocId", 32'(alloc_id), 32'd1);
        checkVal("t4OccFree", 32'(occupancy), 32'd3);

        alloc_valid = 1'b1; alloc_pAddress = 15'h0040;
        step();
        alloc_valid = 1'b0;
        checkVal("t4Hit40", 32'(MSHR_HIT), 32'd1);
        checkVal("t4OccRe", 32'(occupancy), 32'd4);

        alloc_valid = 1'b1; alloc_pAddress = 15'h0050;
        fill_valid = 1'b1;  fill_pAddress = 15'h0000;
        lookup_pAddress = 15'h0050;
        sbQ.push_back('{id: 2'd0, addr: 15'h0000});
        step();
        alloc_valid = 1'b0; fill_valid = 1'b0;
        checkVal("fullRaceOcc", 32'(occupancy), 32'd4);
        step();
        checkVal("fullRaceOcc2", 32'(occupancy), 32'd3);
        checkVal("fullRaceHit", 32'(MSHR_HIT), 32'd0);
        checkVal("fullRaceId", 32'(alloc_id), 32'd0);

        fill_valid = 1'b1; fill_pAddress = 15'h7FF0;
        step();
        fill_valid = 1'b0;
        checkVal("t6Orphan", 32'(fill_orphan), 32'd1);
        checkVal("t6OrphanWake", 32'(wake), 32'd0);
        step();
        checkVal("t6OrphanEnd", 32'(fill_orphan), 32'd0);

        lookup_pAddress = 15'h0020;
        #1;
        checkVal("t6PendHit", 32'(MSHR_HIT), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkVal("t6RstOcc", 32'(occupancy), 32'd0);
        checkVal("t6RstFull", 32'(MSHR_FULL), 32'd0);
        checkVal("t6RstHit", 32'(MSHR_HIT), 32'd0);
        checkVal("t6RstWake", 32'(wake), 32'd0);
        step();
        checkVal("t6RstWake2", 32'(wake), 32'd0);
        checkVal("t6RstAllocId", 32'(alloc_id), 32'd0);

        repeat (4) step();
        checkVal("sbDrained", 32'(sbQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
